// File: rtl/seven_segment_decoder.sv
// Debounced seven-segment pattern reader: synchronizes the segment lines, waits for a
// pattern to hold STABLE_LIMIT clocks, then reports it as a hex digit, blank or error.

module seven_segment_decoder_chk (
  input logic i_Clk,
  input logic i_Reset,
  input logic i_Valid,
  input logic i_Error
);

  a_pulse_exclusive: assert property (@(posedge i_Clk) disable iff (i_Reset)
    !(i_Valid && i_Error));

  a_valid_single: assert property (@(posedge i_Clk) disable iff (i_Reset)
    i_Valid |=> !i_Valid);

  a_error_single: assert property (@(posedge i_Clk) disable iff (i_Reset)
    i_Error |=> !i_Error);

endmodule

module seven_segment_decoder #(
  parameter int STABLE_LIMIT = 250000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank,
  output logic [7:0] o_Valid_Count
);

  localparam int CW = (STABLE_LIMIT > 2) ? $clog2(STABLE_LIMIT) : 1;
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_LIMIT - 2);
  localparam logic [CW-1:0] C_MAX  = CW'(STABLE_LIMIT - 1);
  localparam logic [6:0]    C_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_STABLE = 2'd0,
    S_SETTLE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Returns {legal, digit}; digit is meaningless when legal is 0.
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   f_decode = {1'b1, 4'h0};
      7'h06:   f_decode = {1'b1, 4'h1};
      7'h5B:   f_decode = {1'b1, 4'h2};
      7'h4F:   f_decode = {1'b1, 4'h3};
      7'h66:   f_decode = {1'b1, 4'h4};
      7'h6D:   f_decode = {1'b1, 4'h5};
      7'h7D:   f_decode = {1'b1, 4'h6};
      7'h07:   f_decode = {1'b1, 4'h7};
      7'h7F:   f_decode = {1'b1, 4'h8};
      7'h6F:   f_decode = {1'b1, 4'h9};
      7'h77:   f_decode = {1'b1, 4'hA};
      7'h7C:   f_decode = {1'b1, 4'hB};
      7'h39:   f_decode = {1'b1, 4'hC};
      7'h5E:   f_decode = {1'b1, 4'hD};
      7'h79:   f_decode = {1'b1, 4'hE};
      7'h71:   f_decode = {1'b1, 4'hF};
      default: f_decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [6:0]    w_Pins;
  logic [6:0]    r_Sync1;
  logic [6:0]    r_Sync2;
  logic [6:0]    r_Candidate;
  logic [6:0]    r_Accepted;
  logic [CW-1:0] r_Count;
  state_t        r_State;
  state_t        w_Next_State;
  logic [6:0]    w_Candidate;
  logic [CW-1:0] w_Count;
  logic [4:0]    w_Dec;

  assign w_Pins = ACTIVE_LOW ? ~i_Segments : i_Segments;
  assign w_Dec  = f_decode(r_Candidate);

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Sync1 <= 7'h00;
      r_Sync2 <= 7'h00;
    end else begin
      r_Sync1 <= w_Pins;
      r_Sync2 <= r_Sync1;
    end
  end

  // State, candidate and settle-counter registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= S_STABLE;
      r_Candidate <= 7'h00;
      r_Count     <= C_ZERO;
    end else begin
      r_State     <= w_Next_State;
      r_Candidate <= w_Candidate;
      r_Count     <= w_Count;
    end
  end

  // Next-state logic. The counter saturates at STABLE_LIMIT-1 on the edge that enters
  // S_COMMIT, so the pulse lands STABLE_LIMIT+2 edges after the pattern is first sampled.
  always_comb begin
    w_Next_State = r_State;
    w_Candidate  = r_Candidate;
    w_Count      = r_Count;
    case (r_State)
      S_STABLE: begin
        if (r_Sync2 != r_Accepted) begin
          w_Candidate  = r_Sync2;
          w_Count      = C_ZERO;
          w_Next_State = S_SETTLE;
        end else begin
          w_Next_State = S_STABLE;
        end
      end
      S_SETTLE: begin
        if (r_Sync2 == r_Accepted) begin
          w_Count      = C_ZERO;
          w_Next_State = S_STABLE;
        end else if (r_Sync2 != r_Candidate) begin
          w_Candidate  = r_Sync2;
          w_Count      = C_ZERO;
          w_Next_State = S_SETTLE;
        end else if (r_Count == C_LAST) begin
          w_Count      = C_MAX;
          w_Next_State = S_COMMIT;
        end else begin
          w_Count      = r_Count + C_ONE;
          w_Next_State = S_SETTLE;
        end
      end
      S_COMMIT: begin
        w_Next_State = S_STABLE;
      end
      default: begin
        w_Candidate  = 7'h00;
        w_Count      = C_ZERO;
        w_Next_State = S_STABLE;
      end
    endcase
  end

  // Commit: latch the accepted pattern and drive the registered outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Accepted    <= C_BLANK;
      o_Binary_Num  <= 4'h0;
      o_Valid       <= 1'b0;
      o_Error       <= 1'b0;
      o_Blank       <= 1'b1;
      o_Valid_Count <= 8'h00;
    end else begin
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      if (r_State == S_COMMIT) begin
        r_Accepted <= r_Candidate;
        if (r_Candidate == C_BLANK) begin
          o_Blank <= 1'b1;
        end else if (w_Dec[4]) begin
          o_Binary_Num  <= w_Dec[3:0];
          o_Valid       <= 1'b1;
          o_Blank       <= 1'b0;
          o_Valid_Count <= o_Valid_Count + 8'd1;
        end else begin
          o_Error <= 1'b1;
          o_Blank <= 1'b0;
        end
      end else begin
        r_Accepted <= r_Accepted;
      end
    end
  end

  seven_segment_decoder_chk u_chk (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Valid (o_Valid),
    .i_Error (o_Error)
  );

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: an active-high and an active-low instance see the same
// logical pattern and are both checked each cycle against a run-length acceptance model.

module tb_seven_segment_decoder;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [6:0] seg_n;

  logic [3:0] num0, num1;
  logic       valid0, valid1, error0, error1, blank0, blank1;
  logic [7:0] cnt0, cnt1;
  logic [14:0] obs0, obs1;

  assign obs0 = {num0, valid0, error0, blank0, cnt0};
  assign obs1 = {num1, valid1, error1, blank1, cnt1};

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [0:15];

  // Model: a pattern is accepted once it has been sampled L times in a row and differs
  // from the accepted one; its effect shows 3 edges after the L-th sample.
  logic [6:0] m_acc, run_pat, pend_pat;
  int         run_len, pend_cnt;
  logic [3:0] m_num;
  logic       m_valid, m_error, m_blank;
  logic [7:0] m_cnt;

  localparam logic [14:0] RESET_VEC = {4'h0, 1'b0, 1'b0, 1'b1, 8'h00};

  seven_segment_decoder #(.STABLE_LIMIT(L), .ACTIVE_LOW(1'b0)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Segments(seg),
    .o_Binary_Num(num0), .o_Valid(valid0), .o_Error(error0),
    .o_Blank(blank0), .o_Valid_Count(cnt0)
  );

  seven_segment_decoder #(.STABLE_LIMIT(L), .ACTIVE_LOW(1'b1)) dut_n (
    .i_Clk(clk), .i_Reset(rst), .i_Segments(seg_n),
    .o_Binary_Num(num1), .o_Valid(valid1), .o_Error(error1),
    .o_Blank(blank1), .o_Valid_Count(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec();
    return {m_num, m_valid, m_error, m_blank, m_cnt};
  endfunction

  task automatic model_reset();
    m_acc = 7'h00; run_pat = 7'h00; run_len = 100; pend_cnt = 0; pend_pat = 7'h00;
    m_num = 4'h0; m_valid = 1'b0; m_error = 1'b0; m_blank = 1'b1; m_cnt = 8'h00;
  endtask

  task automatic model_apply(input logic [6:0] p);
    int idx;
    idx = -1;
    for (int i = 0; i < 16; i++) if (seg_tbl[i] == p) idx = i;
    if (p == 7'h00) begin
      m_blank = 1'b1;
    end else if (idx >= 0) begin
      m_num = 4'(idx); m_valid = 1'b1; m_blank = 1'b0; m_cnt = m_cnt + 8'd1;
    end else begin
      m_error = 1'b1; m_blank = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [6:0] x);
    m_valid = 1'b0;
    m_error = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) model_apply(pend_pat);
    end
    if (x == run_pat) begin
      if (run_len < 100) run_len++;
    end else begin
      run_pat = x;
      run_len = 1;
    end
    if (run_len == L && run_pat != m_acc) begin
      m_acc = run_pat; pend_pat = run_pat; pend_cnt = 3;
    end
  endtask

  // Drive one logical pattern for one clock (inverted copy to the active-low instance).
  task automatic step(input logic [6:0] p);
    seg = p;
    seg_n = ~p;
    @(posedge clk);
    model_edge(p);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    seg = 7'h00; seg_n = 7'h7F;
    do_reset();
    checks++;
    if (obs0 !== RESET_VEC || obs1 !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: dut=%h dut_n=%h expected=%h", obs0, obs1, RESET_VEC);
    end
    for (int k = 0; k < 20; k++) begin
      step(7'h00);
      checks++;
      if (obs0 !== RESET_VEC || obs1 !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_hold edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, RESET_VEC);
      end
    end
  endtask

  task automatic test_first_digit();
    int vc0 = 0, vc1 = 0, vedge = -1;
    for (int k = 0; k < 12; k++) begin
      step(7'h4F);
      if (valid0) begin vc0++; vedge = k; end
      if (valid1) vc1++;
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL first_digit edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (vc0 != 1 || vc1 != 1 || vedge != 6 || num0 !== 4'h3 || blank0 !== 1'b0 || cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL first_digit_summary: pulses=%0d/%0d edge=%0d num=%h blank=%b cnt=%0d required 1/1 6 3 0 1",
               vc0, vc1, vedge, num0, blank0, cnt0);
    end
  endtask

  task automatic test_glitch();
    int vc = 0;
    for (int k = 0; k < 14; k++) begin
      step((k < 2) ? 7'h7F : 7'h4F);
      if (valid0 || error0 || valid1 || error1) vc++;
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL glitch edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (vc != 0 || num0 !== 4'h3 || cnt0 !== 8'd1 || num1 !== 4'h3) begin
      errors++;
      $display("FAIL glitch_summary: pulses=%0d num=%h cnt=%0d required 0 3 1", vc, num0, cnt0);
    end
  endtask

  task automatic test_illegal();
    int ec = 0;
    for (int k = 0; k < 12; k++) begin
      step(7'h49);
      if (error0) ec++;
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL illegal edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (ec != 1 || num0 !== 4'h3 || cnt0 !== 8'd1 || blank0 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_summary: errors=%0d num=%h cnt=%0d blank=%b required 1 3 1 0", ec, num0, cnt0, blank0);
    end
  endtask

  task automatic test_hex_f();
    int vc = 0;
    for (int k = 0; k < 12; k++) begin
      step(7'h71);
      if (valid1) vc++;
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL hex_f edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (vc != 1 || num1 !== 4'hF || seg_n !== 7'h0E) begin
      errors++;
      $display("FAIL hex_f_active_low: pulses=%0d num=%h pins=%h required 1 F 0E", vc, num1, seg_n);
    end
  endtask

  task automatic test_blank();
    for (int k = 0; k < 12; k++) begin
      step(7'h00);
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL blank edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (blank0 !== 1'b1 || num0 !== 4'hF || blank1 !== 1'b1) begin
      errors++;
      $display("FAIL blank_summary: blank=%b num=%h required 1 F", blank0, num0);
    end
  endtask

  task automatic test_random();
    logic [6:0] prev, p;
    logic [31:0] r;
    int h;
    prev = 7'h00;
    for (int s = 0; s < 250; s++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: p = seg_tbl[$urandom_range(0, 15)];
        6, 7:             p = 7'h00;
        default:          p = r[6:0];
      endcase
      if (p == prev) p = p ^ 7'h01;
      h = $urandom_range(1, L + 4);
      if (h == L) h = L + 5;
      for (int k = 0; k < h; k++) begin
        step(p);
        checks++;
        if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
          errors++;
          $display("FAIL random seg %0d pat %h edge %0d: dut=%h dut_n=%h expected=%h",
                   s, p, k, obs0, obs1, exp_vec());
        end
      end
      prev = p;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < L + 3; k++) begin
        step(i[0] ? 7'h06 : 7'h3F);
        checks++;
        if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
          errors++;
          $display("FAIL wrap commit %0d edge %0d: dut=%h dut_n=%h expected=%h", i, k, obs0, obs1, exp_vec());
        end
      end
    end
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || num0 !== 4'h1 || num1 !== 4'h1) begin
      errors++;
      $display("FAIL wrap_summary: cnt=%0d/%0d num=%h/%h required 0 1", cnt0, cnt1, num0, num1);
    end
  endtask

  task automatic test_reset_midsettle();
    int vc = 0, vedge = -1;
    for (int k = 0; k < 5; k++) begin
      step(7'h5B);
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL midsettle_pre edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== RESET_VEC || obs1 !== RESET_VEC) begin
      errors++;
      $display("FAIL midsettle_async_reset: dut=%h dut_n=%h expected=%h", obs0, obs1, RESET_VEC);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(7'h5B);
      if (valid0) begin vc++; vedge = k; end
      checks++;
      if (obs0 !== exp_vec() || obs1 !== exp_vec()) begin
        errors++;
        $display("FAIL midsettle_post edge %0d: dut=%h dut_n=%h expected=%h", k, obs0, obs1, exp_vec());
      end
    end
    checks++;
    if (vc != 1 || vedge != L + 2 || num0 !== 4'h2 || cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL midsettle_summary: pulses=%0d edge=%0d num=%h cnt=%0d required 1 %0d 2 1",
               vc, vedge, num0, cnt0, L + 2);
    end
  endtask

  initial begin
    seg_tbl[0]  = 7'h3F; seg_tbl[1]  = 7'h06; seg_tbl[2]  = 7'h5B; seg_tbl[3]  = 7'h4F;
    seg_tbl[4]  = 7'h66; seg_tbl[5]  = 7'h6D; seg_tbl[6]  = 7'h7D; seg_tbl[7]  = 7'h07;
    seg_tbl[8]  = 7'h7F; seg_tbl[9]  = 7'h6F; seg_tbl[10] = 7'h77; seg_tbl[11] = 7'h7C;
    seg_tbl[12] = 7'h39; seg_tbl[13] = 7'h5E; seg_tbl[14] = 7'h79; seg_tbl[15] = 7'h71;
    rst = 1'b1;
    seg = 7'h00;
    seg_n = 7'h7F;
    model_reset();

    test_reset();
    test_first_digit();
    test_glitch();
    test_illegal();
    test_hex_f();
    test_blank();
    test_random();
    test_wrap();
    test_reset_midsettle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 Parameter STABLE_LIMIT, default 250000, SHALL set the clocks a pattern must hold unchanged before acceptance (10 ms at 25 MHz); legal range 2..2^20.
REQ-002 Parameter ACTIVE_LOW, default 0, SHALL invert all segment inputs at the pins when set to 1, so the block reads the panel's inverted drive directly.
REQ-003 i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_Segments  input  7  segment lines, bit0=A .. bit6=G; asynchronous to i_Clk.
REQ-006 o_Binary_Num  output  4  last accepted hex digit.
REQ-007 o_Valid  output  1  one-cycle pulse on each newly accepted legal digit.
REQ-008 o_Error  output  1  one-cycle pulse on each newly accepted illegal pattern.
REQ-009 o_Blank  output  1  level; high while the accepted pattern is all-off.
REQ-010 o_Valid_Count  output  8  count of o_Valid pulses, wraps 255->0.

Function
REQ-011 Inputs SHALL pass through a 2-flop synchronizer (after optional inversion) before any other use.
REQ-012 FSM states SHALL be S_STABLE, S_SETTLE and S_COMMIT.
REQ-013 S_STABLE: if the synced pattern differs from r_Accepted, load it into r_Candidate, clear the counter and go to S_SETTLE; otherwise stay.
REQ-014 S_SETTLE: if synced differs from r_Candidate, reload r_Candidate and clear the counter (restart).
REQ-015 S_SETTLE: if synced equals r_Accepted, return to S_STABLE with no pulse (glitch rejected).
REQ-016 S_SETTLE: when the counter reaches STABLE_LIMIT-1 with the pattern unchanged, go to S_COMMIT.
REQ-017 S_COMMIT (one cycle): r_Accepted<=r_Candidate, decode, register outputs, then go to S_STABLE.
REQ-018 Decode table ({G..A} hex) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 Legal pattern: o_Binary_Num<=digit; o_Valid pulses; o_Valid_Count increments.
REQ-020 Pattern 00: o_Blank<=1; no pulse; o_Binary_Num holds its value.
REQ-021 Any other pattern: o_Error pulses; o_Binary_Num holds its value; o_Blank<=0.
REQ-022 A legal commit SHALL clear o_Blank.
REQ-023 Latency: o_Valid/o_Error SHALL be high in exactly the cycle after the (STABLE_LIMIT+2)th rising edge following the edge that first samples the new pattern, given no intervening change.
REQ-024 o_Valid and o_Error SHALL never be high together, and each SHALL be high for one cycle only.
REQ-025 The counter SHALL be sized for STABLE_LIMIT and SHALL NOT wrap; it stops at STABLE_LIMIT-1.

Reset
REQ-026 On i_Reset high, immediately and asynchronously: synchronizer=0, r_Candidate=0, r_Accepted=00, counter=0, state=S_STABLE, o_Binary_Num=0, o_Valid=0, o_Error=0, o_Blank=1, o_Valid_Count=0.
REQ-027 Reset asserted mid-S_SETTLE SHALL discard the candidate; no pulse after release.
REQ-028 After release with inputs held at 00, no output SHALL change.

Verification (STABLE_LIMIT=4)
REQ-029 Reset, drive 4F, hold -> one o_Valid exactly 6 edges after sampling, o_Binary_Num=3, o_Blank=0, o_Valid_Count=1.
REQ-030 Stable 3; drive 7F for 2 cycles, then 4F -> no pulse, outputs unchanged.
REQ-031 Drive 49 and hold -> one o_Error pulse, o_Binary_Num stays 3, o_Valid_Count unchanged.
REQ-032 ACTIVE_LOW=1: drive ~71 (0E) and hold -> o_Valid, o_Binary_Num=F.
REQ-033 256 alternating legal commits (3F/06) -> o_Valid_Count returns to 0 and ends on digit 0 or 1 as driven.
REQ-034 Assert i_Reset 2 cycles into S_SETTLE of 5B -> all outputs at reset values at once; no o_Valid until 5B settles again after release.
